// File: rtl/snake_engine.sv
// Snake game core: per-tick step FSM (next cell, collision check, commit/grow)
// over a circular body FIFO and an occupancy bitmap, plus a registered cell query.
module snake_engine #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int XW      = 6,
    parameter int YW      = 5,
    parameter int MAX_LEN = 128,
    parameter int LW      = 8,
    parameter int WRAP    = 0,
    parameter int INIT_X  = 20,
    parameter int INIT_Y  = 15
) (
    input  logic          clk,
    input  logic          reset_pix,
    input  logic          tick,
    input  logic [1:0]    dir,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    input  logic [XW-1:0] qry_x,
    input  logic [YW-1:0] qry_y,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          ate,
    output logic          busy,
    output logic          game_over,
    output logic          body_on,
    output logic          head_on
);

    localparam int CELLS    = GRID_W * GRID_H;
    localparam int IW       = $clog2(CELLS);
    localparam int PW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int INIT_IDX = INIT_Y * GRID_W + INIT_X;
    localparam logic [CELLS-1:0]   OCC_INIT  = {{(CELLS-1){1'b0}}, 1'b1} << INIT_IDX;
    localparam logic [XW+YW-1:0]   INIT_CELL = {XW'(INIT_X), YW'(INIT_Y)};

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, DEAD} state_t;
    state_t state, state_next;

    logic [XW+YW-1:0] fifo [MAX_LEN];
    logic [PW-1:0]    head_ptr, tail_ptr;
    logic [CELLS-1:0] occ;
    logic [1:0]       cur_dir, step_dir, req_dir;
    logic [XW-1:0]    nx, cand_x, tail_x;
    logic [YW-1:0]    ny, cand_y, tail_y;
    logic [XW:0]      x_ext;
    logic [YW:0]      y_ext;
    logic             oob, eat, cand_oob;
    logic             grow, tail_ok, occ_hit, hit;
    logic             qry_in, qry_head, qry_occ;
    logic [IW-1:0]    next_idx, tail_idx, qry_idx;

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(y) * IW'(GRID_W) + IW'(x);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    // Candidate head cell; one extra bit per axis so a step below 0 shows up as out of range.
    always_comb begin
        req_dir = (dir == (cur_dir ^ 2'b10)) ? cur_dir : dir;
        x_ext   = {1'b0, head_x};
        y_ext   = {1'b0, head_y};
        case (req_dir)
            2'b00:   y_ext = y_ext - 1'b1;
            2'b01:   x_ext = x_ext + 1'b1;
            2'b10:   y_ext = y_ext + 1'b1;
            default: x_ext = x_ext - 1'b1;
        endcase
        cand_x   = x_ext[XW-1:0];
        cand_y   = y_ext[YW-1:0];
        cand_oob = (x_ext >= (XW+1)'(GRID_W)) || (y_ext >= (YW+1)'(GRID_H));
        if (WRAP != 0) begin
            if (x_ext >= (XW+1)'(GRID_W))
                cand_x = (req_dir == 2'b01) ? '0 : XW'(GRID_W - 1);
            if (y_ext >= (YW+1)'(GRID_H))
                cand_y = (req_dir == 2'b10) ? '0 : YW'(GRID_H - 1);
            cand_oob = 1'b0;
        end
    end

    assign {tail_x, tail_y} = fifo[tail_ptr];
    assign next_idx = cell_idx(nx, ny);
    assign tail_idx = cell_idx(tail_x, tail_y);
    assign qry_idx  = cell_idx(qry_x, qry_y);

    // Stepping into the tail is legal only when that tail cell is vacated by the same move.
    always_comb begin
        grow    = eat && (length < LW'(MAX_LEN));
        tail_ok = (nx == tail_x) && (ny == tail_y) && !grow && (length > LW'(1));
        occ_hit = ({1'b0, next_idx} < (IW+1)'(CELLS)) ? occ[next_idx] : 1'b0;
        hit     = (oob && (WRAP == 0)) || (occ_hit && !tail_ok);
    end

    always_ff @(posedge clk or posedge reset_pix) begin
        if (reset_pix) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = CHECK;
            CHECK:   state_next = hit ? DEAD : COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = DEAD;
        endcase
    end

    assign busy = (state == CHECK) || (state == COMMIT);

    // In COMMIT the push's occupancy set comes after the pop's clear, so it wins on a shared cell.
    always_ff @(posedge clk or posedge reset_pix) begin
        if (reset_pix) begin
            for (int i = 0; i < MAX_LEN; i++) fifo[i] <= INIT_CELL;
            occ       <= OCC_INIT;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            head_x    <= XW'(INIT_X);
            head_y    <= YW'(INIT_Y);
            cur_dir   <= 2'b01;
            step_dir  <= 2'b01;
            length    <= LW'(1);
            nx        <= '0;
            ny        <= '0;
            oob       <= 1'b0;
            eat       <= 1'b0;
            ate       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            ate <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    step_dir <= req_dir;
                    nx       <= cand_x;
                    ny       <= cand_y;
                    oob      <= cand_oob;
                    eat      <= (cand_x == apple_x) && (cand_y == apple_y);
                end
                CHECK: if (hit) game_over <= 1'b1;
                COMMIT: begin
                    if (!grow) begin
                        occ[tail_idx] <= 1'b0;
                        tail_ptr      <= ptr_inc(tail_ptr);
                    end else begin
                        length <= length + 1'b1;
                    end
                    occ[next_idx]           <= 1'b1;
                    fifo[ptr_inc(head_ptr)] <= {nx, ny};
                    head_ptr                <= ptr_inc(head_ptr);
                    head_x                  <= nx;
                    head_y                  <= ny;
                    cur_dir                 <= step_dir;
                    ate                     <= eat;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        qry_in   = ({1'b0, qry_x} < (XW+1)'(GRID_W)) && ({1'b0, qry_y} < (YW+1)'(GRID_H));
        qry_head = (qry_x == head_x) && (qry_y == head_y);
        qry_occ  = qry_in ? occ[qry_idx] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset_pix) begin
        if (reset_pix) begin
            head_on <= 1'b0;
            body_on <= 1'b0;
        end else begin
            head_on <= qry_in && qry_head;
            body_on <= qry_occ && !qry_head;
        end
    end

endmodule
